// File: rtl/ice_sl_frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ice_sl_frame_buffer_pkg
// Purpose  : Shared write-FSM encodings and RAM entry layout for the frame
//            buffer controller.
// Revision : 1.0
// ============================================================================
package ice_sl_frame_buffer_pkg;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FRAME = 2'd1,
        W_DROP  = 2'd2
    } wr_state_e;

    localparam int EOF_BIT = 8;
    localparam int ENTRY_W = 9;

endpackage
`default_nettype wire

// File: rtl/ice_sl_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : ice_sl_frame_buffer_if
// Purpose  : Device write port and bus-controller port of the frame buffer.
// Revision : 1.0
// ============================================================================
interface ice_sl_frame_buffer_if #(
    parameter int ADDR_W = 9
);
    import ice_sl_frame_buffer_pkg::*;

    logic [7:0]         wr_data;
    logic               wr_valid;
    logic               wr_last;
    logic               wr_abort;
    logic               overflow;
    logic [ADDR_W-1:0]  sl_addr;
    logic [ENTRY_W-1:0] sl_data;
    logic [ADDR_W-1:0]  sl_tail;
    logic               sl_latch_tail;
    logic               sl_arb_request;
    logic               sl_arb_grant;
    logic [ADDR_W-1:0]  frame_count;

    modport master (
        output wr_data, wr_valid, wr_last, wr_abort,
        output sl_addr, sl_latch_tail, sl_arb_grant,
        input  overflow, sl_data, sl_tail, sl_arb_request, frame_count
    );

    modport slave (
        input  wr_data, wr_valid, wr_last, wr_abort,
        input  sl_addr, sl_latch_tail, sl_arb_grant,
        output overflow, sl_data, sl_tail, sl_arb_request, frame_count
    );

endinterface
`default_nettype wire

// File: rtl/ice_ring_ram.sv
`default_nettype none
// ============================================================================
// Module   : ice_ring_ram
// Purpose  : Simple dual-port RAM, synchronous write, registered read-first read.
// Revision : 1.0
// ============================================================================
module ice_ring_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 9
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              wr_en_i,
    input  wire logic [ADDR_W-1:0] wr_addr_i,
    input  wire logic [DATA_W-1:0] wr_data_i,
    input  wire logic [ADDR_W-1:0] rd_addr_i,
    output logic      [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/ice_sl_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ice_sl_frame_buffer
// Purpose  : Outgoing frame buffer: commits whole frames into a circular RAM,
//            requests arbitration while frames are pending, frees on tail latch.
// Revision : 1.0
// ============================================================================
module ice_sl_frame_buffer
    import ice_sl_frame_buffer_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ice_sl_frame_buffer_if.slave       fb
);

    wr_state_e          state_q;
    logic [ADDR_W-1:0]  wr_ptr_q;
    logic [ADDR_W-1:0]  head_q;
    logic [ADDR_W-1:0]  tail_q;
    logic [ADDR_W-1:0]  frame_count_q;
    logic               overflow_q;
    logic               arb_q;

    logic [ADDR_W-1:0]  w_wr_ptr_inc;
    logic               w_full;
    logic               w_accepting;
    logic               w_we;
    logic               w_commit;
    logic               w_latch;
    logic [ENTRY_W-1:0] w_entry;
    logic               w_unused_grant;

    assign w_wr_ptr_inc = wr_ptr_q + 1'b1;
    assign w_full       = (w_wr_ptr_inc == tail_q);

    // In W_FRAME an abort wins over a simultaneous byte strobe.
    assign w_accepting  = (state_q == W_IDLE) ||
                          ((state_q == W_FRAME) && !fb.wr_abort);
    assign w_we         = w_accepting && fb.wr_valid && !w_full;
    assign w_commit     = w_we && fb.wr_last;
    assign w_latch      = fb.sl_latch_tail && (frame_count_q != '0);

    always_comb begin
        w_entry          = '0;
        w_entry[EOF_BIT] = fb.wr_last;
        w_entry[7:0]     = fb.wr_data;
    end

    // Grant is status only: device writes continue during a bus transmit.
    assign w_unused_grant = fb.sl_arb_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= W_IDLE;
            wr_ptr_q      <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
            arb_q         <= 1'b0;
        end else begin
            overflow_q <= 1'b0;

            case (state_q)
                W_IDLE, W_FRAME: begin
                    if ((state_q == W_FRAME) && fb.wr_abort) begin
                        wr_ptr_q <= head_q;
                        state_q  <= W_IDLE;
                    end else if (fb.wr_valid) begin
                        if (w_full) begin
                            overflow_q <= 1'b1;
                            wr_ptr_q   <= head_q;
                            state_q    <= fb.wr_last ? W_IDLE : W_DROP;
                        end else begin
                            wr_ptr_q <= w_wr_ptr_inc;
                            if (fb.wr_last) begin
                                head_q  <= w_wr_ptr_inc;
                                state_q <= W_IDLE;
                            end else begin
                                state_q <= W_FRAME;
                            end
                        end
                    end
                end
                W_DROP: begin
                    if (fb.wr_abort || (fb.wr_valid && fb.wr_last)) begin
                        state_q <= W_IDLE;
                    end
                end
                default: state_q <= W_IDLE;
            endcase

            if (w_latch) begin
                tail_q <= fb.sl_addr;
            end

            case ({w_commit, w_latch})
                2'b10:   frame_count_q <= frame_count_q + 1'b1;
                2'b01:   frame_count_q <= frame_count_q - 1'b1;
                default: frame_count_q <= frame_count_q;
            endcase

            arb_q <= (frame_count_q != '0);
        end
    end

    ice_ring_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (w_entry),
        .rd_addr_i (fb.sl_addr),
        .rd_data_o (fb.sl_data)
    );

    assign fb.overflow       = overflow_q;
    assign fb.sl_tail        = tail_q;
    assign fb.sl_arb_request = arb_q;
    assign fb.frame_count    = frame_count_q;

endmodule
`default_nettype wire
